// File: rtl/sim_pkg.sv
// Shared simulation-top types: monitor state, trace record layout and the
// default end-of-test instruction encoding.
package sim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } monState_t;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
  } traceRec_t;

  // ebreak
  localparam logic [31:0] HALT_INST_EBREAK = 32'h00100073;
  localparam int          TRACE_REC_W      = $bits(traceRec_t);

endpackage

// File: rtl/commit_trace_fifo.sv
// Synchronous FIFO for trace records. A push into a full FIFO is accepted
// only when a pop happens on the same edge; otherwise it is discarded and the
// caller is expected to flag the drop. The head reads as zero while empty.
module commit_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 96
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             popOk;
  logic             pushOk;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign popOk   = pop & ~empty;
  assign pushOk  = push & (~full | popOk);
  assign popData = empty ? '0 : mem[rdPtr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/commit_trace_monitor.sv
// Commit trace monitor: captures every retired instruction into a trace
// FIFO for the host checker, counts cycles/instret while the test runs and
// decides pass/fail on ebreak (a0 == 0 passes) or on timeout.
module commit_trace_monitor
  import sim_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] HALT_INST      = HALT_INST_EBREAK
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic        commit_i,
  input  logic [31:0] commit_pc_i,
  input  logic [31:0] commit_inst_i,
  input  logic [31:0] a0_i,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_seq_o,
  output logic [31:0] trace_pc_o,
  output logic [31:0] trace_inst_o,
  output logic [31:0] instret_o,
  output logic [31:0] cycle_o,
  output logic        overflow_o,
  output logic        halted_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o
);

  localparam logic [31:0] LAST_RUN_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  monState_t  state;
  monState_t  nextState;
  logic [31:0] instret;
  logic [31:0] cycleCount;
  logic [31:0] a0Latched;
  logic        overflowFlag;
  logic        timeoutFlag;
  logic        running;
  logic        pushEn;
  logic        popEn;
  logic        haltCommit;
  logic        timeoutHit;
  logic        fifoFull;
  logic        fifoEmpty;
  traceRec_t   pushRec;
  traceRec_t   headRec;

  assign haltCommit = commit_i && (commit_inst_i == HALT_INST);
  assign timeoutHit = (cycleCount == LAST_RUN_CYCLE);
  assign popEn      = ~fifoEmpty & trace_ready_i;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state: halt takes priority over a coincident timeout.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start_i) nextState = RUN;
      RUN:     if (haltCommit || timeoutHit) nextState = DRAIN;
      DRAIN:   if (fifoEmpty) nextState = DONE;
      default: nextState = DONE;
    endcase
  end

  // State-decoded outputs and qualifiers.
  always_comb begin
    running  = (state == RUN);
    halted_o = (state == DONE);
    pushEn   = running & commit_i;
    pass_o   = halted_o & ~timeoutFlag & (a0Latched == '0);
    fail_o   = halted_o & (timeoutFlag | (a0Latched != '0));
  end

  // Run counters, a0 capture and sticky flags; all frozen outside RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret      <= '0;
      cycleCount   <= '0;
      a0Latched    <= '0;
      overflowFlag <= 1'b0;
      timeoutFlag  <= 1'b0;
    end else if (running) begin
      cycleCount <= cycleCount + 1'b1;
      if (commit_i) begin
        instret <= instret + 1'b1;
        if (fifoFull && !popEn) overflowFlag <= 1'b1;
      end
      if (haltCommit)      a0Latched   <= a0_i;
      else if (timeoutHit) timeoutFlag <= 1'b1;
    end
  end

  assign pushRec = '{seq: instret, pc: commit_pc_i, inst: commit_inst_i};

  commit_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRACE_REC_W)
  ) traceFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pushEn),
    .pushData (pushRec),
    .pop      (popEn),
    .popData  (headRec),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign trace_valid_o = ~fifoEmpty;
  assign trace_seq_o   = headRec.seq;
  assign trace_pc_o    = headRec.pc;
  assign trace_inst_o  = headRec.inst;
  assign instret_o     = instret;
  assign cycle_o       = cycleCount;
  assign overflow_o    = overflowFlag;
  assign timeout_o     = timeoutFlag;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Bench for commit_trace_monitor: hand-written vector table and corner-case
// sequences, plus randomized episodes checked against a queue-based model.
module tb_commit_trace_monitor;

  localparam int          DEPTH = 8;
  localparam int          TMO   = 16;
  localparam logic [31:0] HALT  = 32'h00100073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic        commit_i;
  logic [31:0] commit_pc_i;
  logic [31:0] commit_inst_i;
  logic [31:0] a0_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_seq_o;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_inst_o;
  logic [31:0] instret_o;
  logic [31:0] cycle_o;
  logic        overflow_o;
  logic        halted_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;

  always #5 clock = ~clock;

  commit_trace_monitor #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .HALT_INST      (HALT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_i       (start_i),
    .commit_i      (commit_i),
    .commit_pc_i   (commit_pc_i),
    .commit_inst_i (commit_inst_i),
    .a0_i          (a0_i),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .trace_seq_o   (trace_seq_o),
    .trace_pc_o    (trace_pc_o),
    .trace_inst_o  (trace_inst_o),
    .instret_o     (instret_o),
    .cycle_o       (cycle_o),
    .overflow_o    (overflow_o),
    .halted_o      (halted_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the trace as a queue, test phase as a small mode code
  // (0 idle, 1 running, 2 draining, 3 finished), counters as plain integers.
  typedef struct {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
  } rec_t;
  rec_t        q[$];
  int          mMode;
  logic [31:0] mInstret;
  logic [31:0] mCycle;
  logic [31:0] mA0;
  bit          mOvf;
  bit          mTo;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mMode    = 0;
    mInstret = 0;
    mCycle   = 0;
    mA0      = 0;
    mOvf     = 0;
    mTo      = 0;
  endtask

  // One clock edge of the reference behaviour, using the currently driven inputs.
  task automatic modelStep();
    bit          wasEmpty;
    bit          popNow;
    logic [31:0] cycBefore;
    rec_t        r;
    wasEmpty  = (q.size() == 0);
    popNow    = !wasEmpty && trace_ready_i;
    cycBefore = mCycle;
    if (popNow) void'(q.pop_front());
    case (mMode)
      0: if (start_i) mMode = 1;
      1: begin
        mCycle = mCycle + 1;
        if (commit_i) begin
          r.seq  = mInstret;
          r.pc   = commit_pc_i;
          r.inst = commit_inst_i;
          if (q.size() < DEPTH) q.push_back(r);
          else                  mOvf = 1;
          mInstret = mInstret + 1;
        end
        if (commit_i && commit_inst_i == HALT) begin
          mA0   = a0_i;
          mMode = 2;
        end else if (cycBefore == TMO - 1) begin
          mTo   = 1;
          mMode = 2;
        end
      end
      2: if (wasEmpty) mMode = 3;
      default: ;
    endcase
  endtask

  task automatic checkModel(string tag);
    bit          done;
    logic [31:0] eSeq, ePc, eInst;
    done = (mMode == 3);
    eSeq = 0; ePc = 0; eInst = 0;
    if (q.size() > 0) begin
      eSeq  = q[0].seq;
      ePc   = q[0].pc;
      eInst = q[0].inst;
    end
    check1 ({tag, ".valid"},   trace_valid_o, q.size() > 0);
    check32({tag, ".seq"},     trace_seq_o,   eSeq);
    check32({tag, ".pc"},      trace_pc_o,    ePc);
    check32({tag, ".inst"},    trace_inst_o,  eInst);
    check32({tag, ".instret"}, instret_o,     mInstret);
    check32({tag, ".cycle"},   cycle_o,       mCycle);
    check1 ({tag, ".ovf"},     overflow_o,    mOvf);
    check1 ({tag, ".halted"},  halted_o,      done);
    check1 ({tag, ".pass"},    pass_o,        done && !mTo && mA0 == 0);
    check1 ({tag, ".fail"},    fail_o,        done && (mTo || mA0 != 0));
    check1 ({tag, ".timeout"}, timeout_o,     mTo);
  endtask

  // Drive one cycle's inputs (called just after a falling edge), clock it, compare at the next falling edge.
  task automatic drive(string tag, bit st, bit cm, logic [31:0] pc, logic [31:0] inst,
                       logic [31:0] a0, bit rdy);
    start_i       = st;
    commit_i      = cm;
    commit_pc_i   = pc;
    commit_inst_i = inst;
    a0_i          = a0;
    trace_ready_i = rdy;
    @(posedge clock);
    modelStep();
    @(negedge clock);
    checkModel(tag);
  endtask

  task automatic idle(string tag, int n, bit rdy);
    for (int i = 0; i < n; i++) drive(tag, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset         = 1'b1;
    start_i       = 0;
    commit_i      = 0;
    commit_pc_i   = 0;
    commit_inst_i = 0;
    a0_i          = 0;
    trace_ready_i = 0;
    modelReset();
    @(negedge clock);
    checkModel("rst");
    reset = 1'b0;
  endtask

  typedef struct {
    bit          st;
    bit          cm;
    logic [31:0] pc;
    bit          rdy;
    bit          eValid;
    logic [31:0] eSeq;
    logic [31:0] ePc;
    logic [31:0] eInstret;
    logic [31:0] eCycle;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    start_i       = 0;
    commit_i      = 0;
    commit_pc_i   = 0;
    commit_inst_i = 0;
    a0_i          = 0;
    trace_ready_i = 0;
    modelReset();

    // Back-to-back commits with ready high: each record on the head one cycle after its commit.
    tbl[0] = '{st:1, cm:0, pc:32'h0, rdy:1, eValid:0, eSeq:0, ePc:32'h0, eInstret:0, eCycle:0};
    tbl[1] = '{st:0, cm:1, pc:32'h0, rdy:1, eValid:1, eSeq:0, ePc:32'h0, eInstret:1, eCycle:1};
    tbl[2] = '{st:0, cm:1, pc:32'h4, rdy:1, eValid:1, eSeq:1, ePc:32'h4, eInstret:2, eCycle:2};
    tbl[3] = '{st:0, cm:1, pc:32'h8, rdy:1, eValid:1, eSeq:2, ePc:32'h8, eInstret:3, eCycle:3};
    tbl[4] = '{st:0, cm:0, pc:32'h0, rdy:1, eValid:0, eSeq:0, ePc:32'h0, eInstret:3, eCycle:4};
    doReset();
    for (int i = 0; i < 5; i++) begin
      drive("t2", tbl[i].st, tbl[i].cm, tbl[i].pc, NOP, 0, tbl[i].rdy);
      check1 ("t2.tvalid",   trace_valid_o, tbl[i].eValid);
      check32("t2.tseq",     trace_seq_o,   tbl[i].eSeq);
      check32("t2.tpc",      trace_pc_o,    tbl[i].ePc);
      check32("t2.tinstret", instret_o,     tbl[i].eInstret);
      check32("t2.tcycle",   cycle_o,       tbl[i].eCycle);
    end

    // Asynchronous reset mid-run with three records queued.
    doReset();
    drive("t1", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive("t1", 0, 1, 32'(i * 4), NOP, 0, 0);
    check32("t1.queued", instret_o, 3);
    #2 reset = 1'b1;
    modelReset();
    #1;
    check1 ("t1.async.valid", trace_valid_o, 0);
    check32("t1.async.instret", instret_o, 0);
    check32("t1.async.seq", trace_seq_o, 0);
    checkModel("t1.async");
    @(negedge clock);
    reset = 1'b0;
    drive("t1.idle", 0, 1, 32'h40, NOP, 0, 1);
    check32("t1.idle.instret", instret_o, 0);
    check1 ("t1.idle.valid", trace_valid_o, 0);

    // Ten commits into an 8-deep FIFO with no reader.
    doReset();
    drive("t3", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive("t3", 0, 1, 32'h1000 + 32'(i * 4), NOP, 0, 0);
    check1 ("t3.ovf", overflow_o, 1);
    check32("t3.instret", instret_o, 10);
    for (int i = 0; i < 8; i++) begin
      check1 ("t3.dvalid", trace_valid_o, 1);
      check32("t3.dseq", trace_seq_o, 32'(i));
      drive("t3.drain", 0, 0, 0, 0, 0, 1);
    end
    check1("t3.empty", trace_valid_o, 0);

    // Halt with a0 = 0 (pass) and a0 = 1 (fail); commits after DONE are ignored.
    for (int k = 0; k < 2; k++) begin
      doReset();
      drive("t4", 1, 0, 0, 0, 0, 1);
      drive("t4", 0, 1, 32'h100, HALT, 32'(k), 1);
      check1("t4.notdone", halted_o, 0);
      check32("t4.hseq", trace_seq_o, 0);
      check32("t4.hinst", trace_inst_o, HALT);
      idle("t4", 2, 1);
      check1("t4.halted", halted_o, 1);
      check1("t4.pass", pass_o, k == 0);
      check1("t4.fail", fail_o, k == 1);
      drive("t4.late", 0, 1, 32'h104, NOP, 0, 1);
      check32("t4.late.instret", instret_o, 1);
    end

    // Timeout with no halt.
    doReset();
    drive("t5", 1, 0, 0, 0, 0, 1);
    idle("t5", 20, 1);
    check1 ("t5.timeout", timeout_o, 1);
    check1 ("t5.halted", halted_o, 1);
    check1 ("t5.fail", fail_o, 1);
    check1 ("t5.pass", pass_o, 0);
    check32("t5.cycle", cycle_o, TMO);

    // Halt on the final run cycle beats the timeout.
    doReset();
    drive("t6", 1, 0, 0, 0, 0, 1);
    idle("t6", TMO - 1, 1);
    check32("t6.precycle", cycle_o, TMO - 1);
    drive("t6", 0, 1, 32'h200, HALT, 0, 1);
    check1("t6.timeout0", timeout_o, 0);
    idle("t6", 2, 1);
    check1("t6.halted", halted_o, 1);
    check1("t6.pass", pass_o, 1);
    check1("t6.timeout", timeout_o, 0);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 20; ep++) begin
      int rdyPct;
      rdyPct = (ep % 3 == 0) ? 15 : 70;
      doReset();
      for (int c = 0; c < 40; c++) begin
        bit          st, cm, rdy;
        logic [31:0] inst, a0;
        st   = ($urandom_range(0, 3) == 0);
        cm   = ($urandom_range(0, 1) == 1);
        inst = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
        a0   = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom_range(1, 5));
        rdy  = ($urandom_range(0, 99) < rdyPct);
        drive("rnd", st, cm, $urandom, inst, a0, rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
